// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcodes, ALUOp classes and the main control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/main_control.sv
// Main decoder: opcode to control bundle plus an illegal-opcode flag.
// Purely combinational so it can be shared with the single-cycle and multicycle cores.
module main_control
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    output ctrl_t      o_ctrl,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl    = CTRL_NOP;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Instruction-decode stage: register-file read addressing, load-use hazard stall,
// bubble insertion on stall/flush/empty slot, and the ID/EX pipeline register.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW        = 32,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_id,
    input  logic [DW-1:0]    pc4_id,
    input  logic             valid_id,
    input  logic             flush,
    output logic [4:0]       RN1,
    output logic [4:0]       RN2,
    input  logic [DW-1:0]    RD1,
    input  logic [DW-1:0]    RD2,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_RegDst,
    output logic             ex_ALUSrc,
    output logic             ex_MemtoReg,
    output logic             ex_RegWrite,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_Branch,
    output logic [1:0]       ex_ALUOp,
    output logic             ex_illegal,
    output logic [DW-1:0]    ex_rd1,
    output logic [DW-1:0]    ex_rd2,
    output logic [DW-1:0]    ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [5:0]       ex_funct,
    output logic [DW-1:0]    ex_pc4,
    output logic [CNT_W-1:0] stall_count
);

    logic [5:0]    w_opcode;
    ctrl_t         w_ctrl;
    logic          w_illegal;
    logic          w_uses_rs;
    logic          w_uses_rt;
    logic          w_hazard;
    logic          w_bubble;
    logic [DW-1:0] w_imm;

    assign w_opcode = instr_id[31:26];
    assign RN1      = instr_id[25:21];
    assign RN2      = instr_id[20:16];
    assign w_imm    = {{(DW-16){instr_id[15]}}, instr_id[15:0]};

    main_control u_main_control (
        .i_opcode  (w_opcode),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_uses_rs = 1'b0;
        w_uses_rt = 1'b0;
        case (w_opcode)
            OP_RTYPE, OP_SW, OP_BEQ: begin
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            OP_LW, OP_ADDI: w_uses_rs = 1'b1;
            default: ;
        endcase
    end

    // A load into $0 never creates a real dependency, so rt==0 is excluded.
    assign w_hazard = valid_id & ~flush & ex_valid & ex_MemRead & (ex_rt != 5'd0) &
                      ((w_uses_rs & (ex_rt == RN1)) | (w_uses_rt & (ex_rt == RN2)));

    assign stall    = (HAZARD_EN != 0) ? w_hazard : 1'b0;
    assign w_bubble = flush | stall | ~valid_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_RegDst   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_illegal  <= 1'b0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct    <= 6'd0;
            ex_pc4      <= '0;
        end else if (w_bubble) begin
            ex_valid    <= 1'b0;
            ex_RegDst   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_illegal  <= 1'b0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct    <= 6'd0;
            ex_pc4      <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_RegDst   <= w_ctrl.reg_dst;
            ex_ALUSrc   <= w_ctrl.alu_src;
            ex_MemtoReg <= w_ctrl.mem_to_reg;
            ex_RegWrite <= w_ctrl.reg_write;
            ex_MemRead  <= w_ctrl.mem_read;
            ex_MemWrite <= w_ctrl.mem_write;
            ex_Branch   <= w_ctrl.branch;
            ex_ALUOp    <= w_ctrl.alu_op;
            ex_illegal  <= w_illegal;
            ex_rd1      <= RD1;
            ex_rd2      <= RD2;
            ex_imm      <= w_imm;
            ex_rs       <= instr_id[25:21];
            ex_rt       <= instr_id[20:16];
            ex_rd       <= instr_id[15:11];
            ex_funct    <= instr_id[5:0];
            ex_pc4      <= pc4_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
